// File: rtl/tdp_ram_pkg.sv
// Shared definitions for the TDP RAM port A write front end.
//   state_e      : controller states (IDLE/WRITE/FLUSH/DONE)
//   BE_LO/BE_BOTH: byte-enable patterns for the low slot / both slots
//   word_t       : one 9-bit stream word, [8] parity, [7:0] data
//   apply_parity : produces the 9-bit word that is actually written
// Build option: TDP_WRITER_PARITY_GEN_EN regenerates the parity bit as even
// parity over the data byte; without it the incoming parity bit is kept.
package tdp_ram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [1:0] BE_NONE = 2'b00;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_BOTH = 2'b11;

  typedef logic [8:0] word_t;

  function automatic word_t apply_parity(input word_t w);
`ifdef TDP_WRITER_PARITY_GEN_EN
    return {^w[7:0], w[7:0]};
`else
    return w;
`endif
  endfunction

endpackage

// File: rtl/tdp_word_packer.sv
// Packs accepted 9-bit words into port A write beats.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : discard any half-filled pair (new transfer)
//   accept       : a stream word is taken this cycle
//   word         : the word being taken (parity already applied)
//   flush        : write out a held low-slot word on its own
//   issue        : combinational, a write beat is produced this cycle
//   din, be      : registered write data / byte enables for port A
// In 9-bit mode every accepted word is a beat. In 18-bit mode the first word
// of a pair waits in the slot and the second word completes the beat.
module tdp_word_packer
  import tdp_ram_pkg::*;
#(
  parameter int WRITE_WIDTH = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  word_t       word,
  input  logic        flush,
  output logic        issue,
  output logic [17:0] din,
  output logic [1:0]  be
);

  localparam bit WIDE = (WRITE_WIDTH == 18);

  word_t       slot_q, slot_d;
  logic        full_q, full_d;
  logic [17:0] din_q, din_d;
  logic [1:0]  be_q, be_d;

  always_comb begin
    slot_d = slot_q;
    full_d = full_q;
    din_d  = din_q;
    be_d   = be_q;
    issue  = 1'b0;
    if (clear) begin
      slot_d = '0;
      full_d = 1'b0;
    end else if (WIDE) begin
      if (flush && full_q) begin
        issue  = 1'b1;
        din_d  = {9'd0, slot_q};
        be_d   = BE_LO;
        full_d = 1'b0;
      end else if (accept) begin
        if (full_q) begin
          issue  = 1'b1;
          din_d  = {word, slot_q};
          be_d   = BE_BOTH;
          full_d = 1'b0;
        end else begin
          slot_d = word;
          full_d = 1'b1;
        end
      end
    end else if (accept) begin
      issue = 1'b1;
      din_d = {9'd0, word};
      be_d  = BE_LO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      full_q <= 1'b0;
      din_q  <= '0;
      be_q   <= BE_NONE;
    end else begin
      slot_q <= slot_d;
      full_q <= full_d;
      din_q  <= din_d;
      be_q   <= be_d;
    end
  end

  assign din = din_q;
  assign be  = be_q;

endmodule

// File: rtl/tdp_ram_port_a_writer.sv
// Streaming write front end for port A of one TDP_RAM18KX2 half.
// Takes 9-bit words on a valid/ready stream, packs them to WRITE_WIDTH
// (9 or 18) and writes them from base_addr upward, wrapping at DEPTH.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a transfer (only honoured while idle)
//   base_addr, length   : first address and word count, captured on start
//   s_valid/s_data/s_ready : input word stream, s_data[8] is parity
//   addr_A/wen_A/din_A/be_A : registered port A write interface
//   busy, done          : transfer in progress / one-cycle completion pulse
// Build option: TDP_WRITER_PARITY_GEN_EN replaces s_data[8] with even parity
// over s_data[7:0].
//
// state    | meaning
// ST_IDLE  | waiting for start, stream not ready
// ST_WRITE | accepting words until length have been taken
// ST_FLUSH | 18-bit mode with odd length: write the leftover low word
// ST_DONE  | pulse done, drop busy, return to idle
module tdp_ram_port_a_writer
  import tdp_ram_pkg::*;
#(
  parameter int WRITE_WIDTH = 9,
  parameter int ADDR_W      = 12,
  parameter int DEPTH       = 2048
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              s_valid,
  input  logic [8:0]        s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] addr_A,
  output logic              wen_A,
  output logic [17:0]       din_A,
  output logic [1:0]        be_A,
  output logic              busy,
  output logic              done
);

  localparam int                CNT_W     = ADDR_W + 1;
  localparam bit                WIDE      = (WRITE_WIDTH == 18);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [31:0]       DEPTH_U   = 32'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] addr_a_q, addr_a_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              s_ready_q, s_ready_d;
  logic              wen_q, wen_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              pk_clear;
  logic              pk_flush;
  logic              pk_issue;
  logic [CNT_W-1:0]  cnt_inc;
  logic [ADDR_W-1:0] base_mod;
  word_t             word_in;

  assign base_mod = ADDR_W'(32'(base_addr) % DEPTH_U);
  assign word_in  = apply_parity(s_data);
  assign cnt_inc  = cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    s_ready_d = s_ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pk_clear  = 1'b0;
    pk_flush  = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pk_clear = 1'b1;
          len_d    = length;
          cnt_d    = '0;
          busy_d   = 1'b1;
          if (length == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d   = ST_WRITE;
            s_ready_d = 1'b1;
          end
        end
      end
      ST_WRITE: begin
        accept = s_valid && s_ready_q;
        if (accept) begin
          cnt_d = cnt_inc;
          // Dropping ready on the final word guarantees nothing past length
          // is ever taken, since ready is registered.
          if (cnt_inc == len_q) begin
            s_ready_d = 1'b0;
            state_d   = (WIDE && len_q[0]) ? ST_FLUSH : ST_DONE;
          end
        end
      end
      ST_FLUSH: begin
        pk_flush = 1'b1;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address walk is kept apart from the FSM block because it depends on the
  // packer's issue, which in turn depends on accept/flush from the FSM.
  always_comb begin
    wr_addr_d = wr_addr_q;
    addr_a_d  = addr_a_q;
    wen_d     = 1'b0;
    if (pk_clear) begin
      wr_addr_d = base_mod;
    end else if (pk_issue) begin
      wen_d     = 1'b1;
      addr_a_d  = wr_addr_q;
      wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + ADDR_W'(1);
    end
  end

  tdp_word_packer #(
    .WRITE_WIDTH(WRITE_WIDTH)
  ) u_packer (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (pk_clear),
    .accept(accept),
    .word  (word_in),
    .flush (pk_flush),
    .issue (pk_issue),
    .din   (din_A),
    .be    (be_A)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      wr_addr_q <= '0;
      addr_a_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      s_ready_q <= 1'b0;
      wen_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_addr_q <= wr_addr_d;
      addr_a_q  <= addr_a_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      s_ready_q <= s_ready_d;
      wen_q     <= wen_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign s_ready = s_ready_q;
  assign addr_A  = addr_a_q;
  assign wen_A   = wen_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule
